vadd_tile_scheduler: RTL and testbench
======================================

// Module: vadd_tile_scheduler
// PURPOSE
//  Sequences the vadd datapath over a large transfer by splitting size_in_bytes into
//  tiles of at most C_TILE_BYTES. Sits between the kernel ap_ctrl logic and the vadd
//  datapath: one ap_start launches N datapath runs, and ap_done fires after the last.
//  Bounds each datapath run so that read/write bursts and FIFOs stay sized per tile.
// PARAMETERS
//  C_ADDR_WIDTH       64    width of base/tile addresses
//  C_XFER_SIZE_WIDTH  32    width of byte counts
//  C_TILE_BYTES       4096  maximum bytes per datapath run; power of 2, >= C_ALIGN_BYTES
//  C_ALIGN_BYTES      16    required size alignment (= AXI data width / 8); power of 2
// PORTS
//  ap_clk        in   1                  clock
//  areset        in   1                  reset, synchronous, active-high
//  ap_start      in   1                  level; the rising edge starts a job
//  ap_idle       out  1                  high while in IDLE
//  ap_done       out  1                  1-cycle pulse at job end
//  ap_err        out  1                  1-cycle pulse with ap_done if size is misaligned
//  size_in_bytes in   C_XFER_SIZE_WIDTH  total job size, sampled on the start edge
//  src_base      in   C_ADDR_WIDTH       read base address, sampled on the start edge
//  dst_base      in   C_ADDR_WIDTH       write base address, sampled on the start edge
//  dp_start      out  1                  1-cycle pulse that launches one datapath run
//  dp_addr_rd    out  C_ADDR_WIDTH       tile read address, stable from dp_start to dp_done
//  dp_addr_wr    out  C_ADDR_WIDTH       tile write address, stable from dp_start to dp_done
//  dp_xfer_size  out  C_XFER_SIZE_WIDTH  tile byte count, stable from dp_start to dp_done
//  dp_done       in   1                  datapath run complete (pulse or level; sampled in WAIT only)
//  tile_idx      out  C_XFER_SIZE_WIDTH  index of the current tile, 0-based
// BEHAVIOUR
//  Reset values
//  - All outputs are 0, except ap_idle = 1. State is IDLE.
//  - The start-edge register resets to 1, so ap_start held high through reset does not start a job.
//  Start
//  - start_edge = ap_start & ~ap_start_r. It is honoured only in IDLE; edges in other states are dropped.
//  - On the edge, the block latches size and bases, clears offset and tile_idx, and moves to CHECK.
//  State machine: IDLE -> CHECK -> LAUNCH -> WAIT -> (LAUNCH | DONE) -> IDLE
//  - CHECK:
//    - size == 0: go to DONE with ap_err = 0.
//    - size % C_ALIGN_BYTES != 0: go to DONE with ap_err = 1. No dp_start is issued.
//    - Otherwise: go to LAUNCH with remaining = size.
//  - LAUNCH:
//    - dp_start = 1 for exactly 1 cycle.
//    - dp_xfer_size = min(remaining, C_TILE_BYTES).
//    - dp_addr_rd = src_base + offset; dp_addr_wr = dst_base + offset.
//    - Offset is zero-extended to C_ADDR_WIDTH; the sum wraps modulo 2^C_ADDR_WIDTH.
//    - Next state is WAIT.
//  - WAIT:
//    - The block holds dp_* stable and waits for dp_done = 1.
//    - On dp_done: remaining -= dp_xfer_size, offset += dp_xfer_size, tile_idx += 1.
//    - If the new remaining == 0, go to DONE; else go to LAUNCH.
//  - DONE: ap_done = 1 (plus ap_err if flagged) for 1 cycle, then IDLE.
//  ap_idle
//  - ap_idle = 1 only in IDLE. It falls the cycle after the start edge.
//  - It rises the cycle after ap_done.
//  Latency
//  - Start edge at T: CHECK at T+1, first dp_start at T+2.
//  - dp_done at D: next dp_start at D+1, or ap_done at D+1 after the last tile.
//  - Zero or misaligned size: ap_done at T+2.
//  Boundaries
//  - dp_done outside WAIT is ignored.
//  - dp_done held high into the next WAIT counts once per WAIT entry. The datapath deasserts it before re-asserting.
//  - When size is an exact multiple of C_TILE_BYTES, there is no trailing zero-length tile.
//  - remaining never underflows: dp_xfer_size <= remaining by construction.
//  - Reset mid-job: return to IDLE next cycle, with no dp_start and no ap_done. A later stale dp_done is ignored.
//  - A start edge in the DONE cycle is dropped. The host re-raises ap_start after ap_done.
// STRUCTURE
//  - Package vadd_sched_pkg holds:
//    - sched_state_t enum {S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_DONE}
//    - localparams for the tile and align log2 values
//    - function tile_len(remaining) returning min(remaining, C_TILE_BYTES)
//  - Sub-module vadd_sched_tile_gen holds the remaining/offset/tile_idx registers and the address adders.
//    - Controlled by load and advance strobes from the FSM.
//    - Keeps the wide adders out of the FSM's critical path.
// TESTING
//  - size=10000, src=0x1000, dst=0x8000, tile 4096:
//    - 3 dp_starts, sizes 4096, 4096, 1808
//    - rd addresses 0x1000, 0x2000, 0x3000; wr addresses 0x8000, 0x9000, 0xA000
//    - one ap_done, ap_err=0
//  - size=8192: exactly 2 tiles of 4096, no third dp_start; ap_done 1 cycle after the 2nd dp_done.
//  - size=0, and separately size=100:
//    - no dp_start, ap_done at T+2
//    - ap_err=0 for size 0; ap_err=1 for size 100
//  - Second ap_start edge during WAIT: ignored; tile count and ap_done count are unchanged.
//  - areset asserted in WAIT of tile 1, then dp_done pulsed:
//    - block stays in IDLE, ap_idle=1, no ap_done
//    - next job runs correctly from offset 0
//  - src_base=0xFFFF_FFFF_FFFF_F000, size=8192: 2nd tile rd address wraps to 0x0.
//    Random dp_done latency of 1 to 50 cycles throughout; dp_* stay stable while in WAIT.

Source files
------------

// File: rtl/vadd_sched_pkg.sv
// Shared types and helpers for the vadd tile scheduler: FSM state encoding,
// default tile/alignment sizes and the per-tile length function.
package vadd_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } sched_state_t;

    localparam int TILE_LOG2  = 12;
    localparam int ALIGN_LOG2 = 4;

    // Length of the next tile: whatever is left, capped at one tile.
    function automatic logic [63:0] tile_len(input logic [63:0] remaining,
                                             input logic [63:0] tile_bytes);
        return (remaining < tile_bytes) ? remaining : tile_bytes;
    endfunction

endpackage

// File: rtl/vadd_sched_tile_gen.sv
// Tile bookkeeping for the vadd scheduler: remaining bytes, running tile
// addresses and tile index, updated by load/advance strobes from the FSM.
module vadd_sched_tile_gen
    import vadd_sched_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_TILE_BYTES      = 4096
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         load,
    input  logic                         advance,
    input  logic [C_XFER_SIZE_WIDTH-1:0] size,
    input  logic [C_ADDR_WIDTH-1:0]      src_base,
    input  logic [C_ADDR_WIDTH-1:0]      dst_base,
    output logic [C_XFER_SIZE_WIDTH-1:0] remaining,
    output logic [C_XFER_SIZE_WIDTH-1:0] xfer_size,
    output logic [C_XFER_SIZE_WIDTH-1:0] tile_idx,
    output logic [C_ADDR_WIDTH-1:0]      addr_rd,
    output logic [C_ADDR_WIDTH-1:0]      addr_wr,
    output logic                         last_tile
);

    assign xfer_size = C_XFER_SIZE_WIDTH'(tile_len(64'(remaining), 64'(C_TILE_BYTES)));
    assign last_tile = (remaining == xfer_size);

    // Address registers carry base + offset directly, so the offset is never
    // held separately and the 64-bit sums wrap naturally.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            remaining <= '0;
            tile_idx  <= '0;
            addr_rd   <= '0;
            addr_wr   <= '0;
        end else if (load) begin
            remaining <= size;
            tile_idx  <= '0;
            addr_rd   <= src_base;
            addr_wr   <= dst_base;
        end else if (advance) begin
            remaining <= remaining - xfer_size;
            tile_idx  <= tile_idx + C_XFER_SIZE_WIDTH'(1);
            addr_rd   <= addr_rd + C_ADDR_WIDTH'(xfer_size);
            addr_wr   <= addr_wr + C_ADDR_WIDTH'(xfer_size);
        end
    end

endmodule

// File: rtl/vadd_tile_scheduler.sv
// Splits one ap_start job into datapath runs of at most C_TILE_BYTES each,
// launching them back to back and signalling ap_done after the last one.
module vadd_tile_scheduler
    import vadd_sched_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_TILE_BYTES      = 1 << TILE_LOG2,
    parameter int C_ALIGN_BYTES     = 1 << ALIGN_LOG2
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_err,
    input  logic [C_XFER_SIZE_WIDTH-1:0] size_in_bytes,
    input  logic [C_ADDR_WIDTH-1:0]      src_base,
    input  logic [C_ADDR_WIDTH-1:0]      dst_base,
    output logic                         dp_start,
    output logic [C_ADDR_WIDTH-1:0]      dp_addr_rd,
    output logic [C_ADDR_WIDTH-1:0]      dp_addr_wr,
    output logic [C_XFER_SIZE_WIDTH-1:0] dp_xfer_size,
    input  logic                         dp_done,
    output logic [C_XFER_SIZE_WIDTH-1:0] tile_idx
);

    localparam logic [C_XFER_SIZE_WIDTH-1:0] ALIGN_MASK = C_XFER_SIZE_WIDTH'(C_ALIGN_BYTES - 1);

    sched_state_t                 state, state_nxt;
    logic                         ap_start_r, err_r;
    logic                         start_edge, load, advance, last_tile;
    logic                         size_zero, misaligned;
    logic [C_XFER_SIZE_WIDTH-1:0] remaining;

    assign start_edge = ap_start & ~ap_start_r;
    assign size_zero  = (remaining == '0);
    assign misaligned = |(remaining & ALIGN_MASK);

    always_ff @(posedge ap_clk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Edge register resets high so a start held through reset is not a new job.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            ap_start_r <= 1'b1;
            err_r      <= 1'b0;
        end else begin
            ap_start_r <= ap_start;
            if (load)                err_r <= 1'b0;
            else if (state == S_CHECK) err_r <= misaligned;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_edge) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (size_zero || misaligned) ? S_DONE : S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (dp_done) state_nxt = last_tile ? S_DONE : S_LAUNCH;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ap_idle  = (state == S_IDLE);
        ap_done  = (state == S_DONE);
        ap_err   = (state == S_DONE) && err_r;
        dp_start = (state == S_LAUNCH);
        load     = (state == S_IDLE) && start_edge;
        advance  = (state == S_WAIT) && dp_done;
    end

    vadd_sched_tile_gen #(
        .C_ADDR_WIDTH      (C_ADDR_WIDTH),
        .C_XFER_SIZE_WIDTH (C_XFER_SIZE_WIDTH),
        .C_TILE_BYTES      (C_TILE_BYTES)
    ) u_tile_gen (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .load      (load),
        .advance   (advance),
        .size      (size_in_bytes),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .remaining (remaining),
        .xfer_size (dp_xfer_size),
        .tile_idx  (tile_idx),
        .addr_rd   (dp_addr_rd),
        .addr_wr   (dp_addr_wr),
        .last_tile (last_tile)
    );

endmodule

// File: tb/tb_vadd_tile_scheduler.sv
// Directed bench for vadd_tile_scheduler: a datapath responder with random
// dp_done latency, a tiny tile model, and hand-computed per-job expectations.
module tb_vadd_tile_scheduler;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        ap_start = 1'b1;
    logic        ap_idle, ap_done, ap_err;
    logic [31:0] size_in_bytes = '0;
    logic [63:0] src_base = '0;
    logic [63:0] dst_base = '0;
    logic        dp_start;
    logic [63:0] dp_addr_rd, dp_addr_wr;
    logic [31:0] dp_xfer_size;
    logic        dp_done = 1'b0;
    logic [31:0] tile_idx;

    int ncmp = 0;
    int nbad = 0;

    int          n_tiles;
    int          done_k;
    logic        err_seen;
    logic [63:0] sz_q [8];
    logic [63:0] rd_q [8];
    logic [63:0] wr_q [8];

    always #5 ap_clk = ~ap_clk;

    vadd_tile_scheduler dut (
        .ap_clk        (ap_clk),
        .areset        (areset),
        .ap_start      (ap_start),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done),
        .ap_err        (ap_err),
        .size_in_bytes (size_in_bytes),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .dp_start      (dp_start),
        .dp_addr_rd    (dp_addr_rd),
        .dp_addr_wr    (dp_addr_wr),
        .dp_xfer_size  (dp_xfer_size),
        .dp_done       (dp_done),
        .tile_idx      (tile_idx)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Runs one job; checks every launch/hold cycle against a small tile model
    // and records what the DUT launched for the caller's hand-made checks.
    task automatic run_job(input logic [31:0] size, input logic [63:0] src,
                           input logic [63:0] dst, input bit inject);
        logic [63:0] rem, off, exp_sz;
        int          k, lat;
        bit          done;
        rem = 64'(size); off = '0; k = 0; done = 0;
        n_tiles = 0; done_k = -1; err_seen = 1'b0;
        size_in_bytes = size; src_base = src; dst_base = dst;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        chk("idle_fall", 64'(ap_idle), 64'd0);
        step();
        k = 2;
        while (!done && k < 2000) begin
            if (ap_done) begin
                done = 1; done_k = k; err_seen = ap_err;
                chk("done_no_dpstart", 64'(dp_start), 64'd0);
            end else if (dp_start) begin
                exp_sz = (rem > 64'd4096) ? 64'd4096 : rem;
                if (n_tiles < 8) begin
                    sz_q[n_tiles] = 64'(dp_xfer_size);
                    rd_q[n_tiles] = dp_addr_rd;
                    wr_q[n_tiles] = dp_addr_wr;
                end
                chk("launch_size", 64'(dp_xfer_size), exp_sz);
                chk("launch_rd", dp_addr_rd, src + off);
                chk("launch_wr", dp_addr_wr, dst + off);
                chk("launch_idx", 64'(tile_idx), 64'(n_tiles));
                lat = $urandom_range(1, 50);
                if (inject && n_tiles == 1) begin
                    ap_start = 1'b1;
                    step();
                    ap_start = 1'b0;
                    k++;
                    chk("inject_no_dpstart", 64'(dp_start), 64'd0);
                end
                for (int i = 0; i < lat; i++) begin
                    step();
                    chk("hold_dpstart", 64'(dp_start), 64'd0);
                    chk("hold_size", 64'(dp_xfer_size), exp_sz);
                    chk("hold_rd", dp_addr_rd, src + off);
                    chk("hold_wr", dp_addr_wr, dst + off);
                end
                dp_done = 1'b1;
                step();
                dp_done = 1'b0;
                k += lat + 1;
                n_tiles++;
                rem -= exp_sz;
                off += exp_sz;
                chk("post_done_apdone", 64'(ap_done), 64'(rem == 0));
                chk("post_done_dpstart", 64'(dp_start), 64'(rem != 0));
            end else begin
                step();
                k++;
            end
        end
        if (!done) chk("job_timeout", 64'd0, 64'd1);
        step();
        chk("idle_rise", 64'(ap_idle), 64'd1);
        chk("done_pulse_1cyc", 64'(ap_done), 64'd0);
    endtask

    initial begin
        // reset with ap_start held high
        step(); step();
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_err", 64'(ap_err), 64'd0);
        chk("rst_dpstart", 64'(dp_start), 64'd0);
        chk("rst_rd", dp_addr_rd, 64'd0);
        chk("rst_wr", dp_addr_wr, 64'd0);
        chk("rst_size", 64'(dp_xfer_size), 64'd0);
        chk("rst_idx", 64'(tile_idx), 64'd0);
        areset = 1'b0;
        repeat (3) step();
        chk("held_start_idle", 64'(ap_idle), 64'd1);
        ap_start = 1'b0;
        step();

        // 10000 bytes: 4096 + 4096 + 1808
        run_job(32'd10000, 64'h1000, 64'h8000, 1'b0);
        chk("j1_tiles", 64'(n_tiles), 64'd3);
        chk("j1_sz0", sz_q[0], 64'd4096);
        chk("j1_sz1", sz_q[1], 64'd4096);
        chk("j1_sz2", sz_q[2], 64'd1808);
        chk("j1_rd0", rd_q[0], 64'h1000);
        chk("j1_rd1", rd_q[1], 64'h2000);
        chk("j1_rd2", rd_q[2], 64'h3000);
        chk("j1_wr0", wr_q[0], 64'h8000);
        chk("j1_wr1", wr_q[1], 64'h9000);
        chk("j1_wr2", wr_q[2], 64'hA000);
        chk("j1_err", 64'(err_seen), 64'd0);

        // exact multiple of the tile: no trailing zero-length tile
        run_job(32'd8192, 64'h20000, 64'h30000, 1'b0);
        chk("j2_tiles", 64'(n_tiles), 64'd2);
        chk("j2_sz1", sz_q[1], 64'd4096);
        chk("j2_err", 64'(err_seen), 64'd0);

        // zero and misaligned sizes
        run_job(32'd0, 64'h1000, 64'h8000, 1'b0);
        chk("j3_tiles", 64'(n_tiles), 64'd0);
        chk("j3_done_lat", 64'(done_k), 64'd2);
        chk("j3_err", 64'(err_seen), 64'd0);
        run_job(32'd100, 64'h1000, 64'h8000, 1'b0);
        chk("j4_tiles", 64'(n_tiles), 64'd0);
        chk("j4_done_lat", 64'(done_k), 64'd2);
        chk("j4_err", 64'(err_seen), 64'd1);

        // second start edge during WAIT is dropped
        run_job(32'd10000, 64'h1000, 64'h8000, 1'b1);
        chk("j5_tiles", 64'(n_tiles), 64'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("j5_stays_idle", 64'(ap_idle), 64'd1);
            chk("j5_no_extra_done", 64'(ap_done), 64'd0);
        end

        // reset in WAIT of tile 1, then a stale dp_done
        size_in_bytes = 32'd10000; src_base = 64'h1000; dst_base = 64'h8000;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        step();
        chk("r_launch0", 64'(dp_start), 64'd1);
        step();
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        chk("r_launch1", 64'(dp_start), 64'd1);
        chk("r_idx1", 64'(tile_idx), 64'd1);
        step(); step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("r_idle", 64'(ap_idle), 64'd1);
        chk("r_idx_clr", 64'(tile_idx), 64'd0);
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("r_stale_idle", 64'(ap_idle), 64'd1);
            chk("r_stale_done", 64'(ap_done), 64'd0);
            chk("r_stale_dpstart", 64'(dp_start), 64'd0);
            step();
        end
        run_job(32'd8192, 64'h1000, 64'h40000, 1'b0);
        chk("r_job_tiles", 64'(n_tiles), 64'd2);
        chk("r_job_rd0", rd_q[0], 64'h1000);
        chk("r_job_rd1", rd_q[1], 64'h2000);
        chk("r_job_wr1", wr_q[1], 64'h41000);

        // source address wraps past 2^64
        run_job(32'd8192, 64'hFFFF_FFFF_FFFF_F000, 64'h8000, 1'b0);
        chk("w_tiles", 64'(n_tiles), 64'd2);
        chk("w_rd0", rd_q[0], 64'hFFFF_FFFF_FFFF_F000);
        chk("w_rd1", rd_q[1], 64'h0);

        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end

endmodule
